// File: rtl/h264_xform_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// h264_xform_pkg -- shared tags, states and widths for the transform scheduler
// Revision: 1.0
// -----------------------------------------------------------------------------
package h264_xform_pkg;

  localparam int ROW_W  = 36;
  localparam int COEF_W = 14;

  typedef enum logic [0:0] {
    SRC_LUMA   = 1'b0,
    SRC_CHROMA = 1'b1
  } src_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FEED = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/h264_xform_tagfifo.sv
`default_nettype none
// -----------------------------------------------------------------------------
// h264_xform_tagfifo -- source-tag FIFO, head kept in slot 0 (shift on pop)
// Revision: 1.0
// -----------------------------------------------------------------------------
module h264_xform_tagfifo
  import h264_xform_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  src_e       push_tag,
  input  logic       pop,
  output logic [2:0] count,
  output src_e       head
);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [2:0]       wr_idx;
  logic             do_pop, do_push;

  always_comb begin
    do_pop  = pop && (cnt_q != 3'd0);
    do_push = push && ((cnt_q != 3'(DEPTH)) || do_pop);
    mem_d   = mem_q;
    cnt_d   = cnt_q;
    wr_idx  = cnt_q;
    if (do_pop) begin
      mem_d  = mem_q >> 1;
      cnt_d  = cnt_q - 3'd1;
      wr_idx = cnt_q - 3'd1;
    end
    if (do_push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_idx == 3'(i)) mem_d[i] = push_tag;
      end
      cnt_d = cnt_d + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
      cnt_q <= 3'd0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign head  = src_e'(mem_q[0]);

endmodule
`default_nettype wire

// File: rtl/h264_xform_sched.sv
`default_nettype none
// -----------------------------------------------------------------------------
// h264_xform_sched -- luma/chroma row arbiter feeding a 4x4 transform core,
// tags returning coefficients. Option: XFORM_SCHED_STATS_EN adds block counters.
// Revision: 1.0
// -----------------------------------------------------------------------------
module h264_xform_sched
  import h264_xform_pkg::*;
#(
  parameter int MAX_INFLIGHT = 2,
  parameter int LUMA_WEIGHT  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              luma_req,
  input  logic [ROW_W-1:0]  luma_xx,
  output logic              luma_ack,
  input  logic              chroma_req,
  input  logic [ROW_W-1:0]  chroma_xx,
  output logic              chroma_ack,
  input  logic              tx_ready,
  output logic              tx_enable,
  output logic [ROW_W-1:0]  tx_xxin,
  input  logic              tx_valid,
  input  logic [COEF_W-1:0] tx_yn,
  output logic              out_valid,
  output logic [COEF_W-1:0] out_yn,
  output logic              out_src,
  output logic [3:0]        out_idx,
  output logic              out_last,
  output logic              err
`ifdef XFORM_SCHED_STATS_EN
  ,
  output logic [15:0]       luma_blks,
  output logic [15:0]       chroma_blks
`endif
);

  state_e            state_q, state_d;
  logic [1:0]        row_q, row_d;
  src_e              grant_q, grant_d;
  logic [3:0]        credit_q, credit_d;
  logic [3:0]        idx_q, idx_d;
  logic              err_q, err_d;
  logic              out_valid_q, out_valid_d;
  logic [COEF_W-1:0] out_yn_q, out_yn_d;
  logic              out_src_q, out_src_d;
  logic [3:0]        out_idx_q, out_idx_d;
  logic              out_last_q, out_last_d;

  logic [2:0]        inflight;
  src_e              head_tag, arb_tag, sel;
  logic              fifo_pop, issue, slot_free, fifo_nonempty;

  h264_xform_tagfifo #(.DEPTH(MAX_INFLIGHT)) u_tagfifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (issue),
    .push_tag (arb_tag),
    .pop      (fifo_pop),
    .count    (inflight),
    .head     (head_tag)
  );

  always_comb begin
    fifo_nonempty = (inflight != 3'd0);
    fifo_pop      = tx_valid && fifo_nonempty && (idx_q == 4'd15);
    // A block finishing this cycle frees its slot for a same-cycle issue.
    slot_free     = (inflight < 3'(MAX_INFLIGHT)) || fifo_pop;
    arb_tag       = (luma_req && (!chroma_req || (credit_q != 4'd0))) ? SRC_LUMA : SRC_CHROMA;
    issue         = (state_q == ST_IDLE) && (luma_req || chroma_req) && tx_ready && slot_free;
    sel           = (state_q == ST_FEED) ? grant_q : arb_tag;

    tx_enable  = issue || (state_q == ST_FEED);
    tx_xxin    = '0;
    if (tx_enable) tx_xxin = (sel == SRC_CHROMA) ? chroma_xx : luma_xx;
    luma_ack   = tx_enable && (sel == SRC_LUMA);
    chroma_ack = tx_enable && (sel == SRC_CHROMA);

    state_d  = state_q;
    row_d    = row_q;
    grant_d  = grant_q;
    credit_d = credit_q;
    idx_d    = idx_q;
    err_d    = err_q;

    if (issue) begin
      state_d = ST_FEED;
      row_d   = 2'd1;
      grant_d = arb_tag;
      if (arb_tag == SRC_CHROMA) credit_d = 4'(LUMA_WEIGHT);
      else if (chroma_req)       credit_d = credit_q - 4'd1;
    end else if (state_q == ST_FEED) begin
      row_d = row_q + 2'd1;
      if (row_q == 2'd3) state_d = ST_IDLE;
      if ((grant_q == SRC_LUMA) ? !luma_req : !chroma_req) err_d = 1'b1;
    end

    if (tx_valid) begin
      idx_d = idx_q + 4'd1;
      if (!fifo_nonempty) err_d = 1'b1;
    end

    out_valid_d = tx_valid && fifo_nonempty;
    out_yn_d    = out_valid_d ? tx_yn : out_yn_q;
    out_src_d   = out_valid_d ? head_tag : out_src_q;
    out_idx_d   = out_valid_d ? idx_q : out_idx_q;
    out_last_d  = out_valid_d && (idx_q == 4'd15);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      row_q       <= 2'd0;
      grant_q     <= SRC_LUMA;
      credit_q    <= 4'(LUMA_WEIGHT);
      idx_q       <= 4'd0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_yn_q    <= '0;
      out_src_q   <= 1'b0;
      out_idx_q   <= 4'd0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      grant_q     <= grant_d;
      credit_q    <= credit_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_yn_q    <= out_yn_d;
      out_src_q   <= out_src_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_yn    = out_yn_q;
  assign out_src   = out_src_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign err       = err_q;

`ifdef XFORM_SCHED_STATS_EN
  logic [15:0] luma_blks_q, luma_blks_d, chroma_blks_q, chroma_blks_d;

  always_comb begin
    luma_blks_d   = luma_blks_q;
    chroma_blks_d = chroma_blks_q;
    if (fifo_pop && (head_tag == SRC_LUMA) && (luma_blks_q != 16'hFFFF))
      luma_blks_d = luma_blks_q + 16'd1;
    if (fifo_pop && (head_tag == SRC_CHROMA) && (chroma_blks_q != 16'hFFFF))
      chroma_blks_d = chroma_blks_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      luma_blks_q   <= 16'd0;
      chroma_blks_q <= 16'd0;
    end else begin
      luma_blks_q   <= luma_blks_d;
      chroma_blks_q <= chroma_blks_d;
    end
  end

  assign luma_blks   = luma_blks_q;
  assign chroma_blks = chroma_blks_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_h264_xform_sched.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_h264_xform_sched -- scoreboard bench with a behavioural transform core
// Revision: 1.0
// -----------------------------------------------------------------------------
module tb_h264_xform_sched;
  import h264_xform_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        luma_req, chroma_req, tx_ready, tx_valid;
  logic [35:0] luma_xx, chroma_xx;
  logic [13:0] tx_yn;
  wire         luma_ack, chroma_ack, tx_enable, out_valid, out_src, out_last, err;
  wire  [35:0] tx_xxin;
  wire  [13:0] out_yn;
  wire  [3:0]  out_idx;

  logic        m1_luma_req, m1_chroma_req, m1_tx_ready, m1_tx_valid;
  logic [35:0] m1_luma_xx, m1_chroma_xx;
  logic [13:0] m1_tx_yn;
  wire         m1_luma_ack, m1_chroma_ack, m1_tx_enable, m1_out_valid, m1_out_src, m1_out_last, m1_err;
  wire  [35:0] m1_tx_xxin;
  wire  [13:0] m1_out_yn;
  wire  [3:0]  m1_out_idx;
`ifdef XFORM_SCHED_STATS_EN
  wire  [15:0] luma_blks, chroma_blks, m1_luma_blks, m1_chroma_blks;
`endif

  h264_xform_sched dut (
    .clk(clk), .rst_n(rst_n),
    .luma_req(luma_req), .luma_xx(luma_xx), .luma_ack(luma_ack),
    .chroma_req(chroma_req), .chroma_xx(chroma_xx), .chroma_ack(chroma_ack),
    .tx_ready(tx_ready), .tx_enable(tx_enable), .tx_xxin(tx_xxin),
    .tx_valid(tx_valid), .tx_yn(tx_yn),
    .out_valid(out_valid), .out_yn(out_yn), .out_src(out_src),
    .out_idx(out_idx), .out_last(out_last), .err(err)
`ifdef XFORM_SCHED_STATS_EN
    , .luma_blks(luma_blks), .chroma_blks(chroma_blks)
`endif
  );

  h264_xform_sched #(.MAX_INFLIGHT(1)) dut_m1 (
    .clk(clk), .rst_n(rst_n),
    .luma_req(m1_luma_req), .luma_xx(m1_luma_xx), .luma_ack(m1_luma_ack),
    .chroma_req(m1_chroma_req), .chroma_xx(m1_chroma_xx), .chroma_ack(m1_chroma_ack),
    .tx_ready(m1_tx_ready), .tx_enable(m1_tx_enable), .tx_xxin(m1_tx_xxin),
    .tx_valid(m1_tx_valid), .tx_yn(m1_tx_yn),
    .out_valid(m1_out_valid), .out_yn(m1_out_yn), .out_src(m1_out_src),
    .out_idx(m1_out_idx), .out_last(m1_out_last), .err(m1_err)
`ifdef XFORM_SCHED_STATS_EN
    , .luma_blks(m1_luma_blks), .chroma_blks(m1_chroma_blks)
`endif
  );

  typedef struct packed {
    logic        src;
    logic [3:0]  idx;
    logic [13:0] yn;
    logic        last;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_miss = 0;
  int   exp_seq = 0;
  int   rows_rx = 0;
  int   blks_out = 0;
  int   inj_req = 0;
  int   inj_done = 0;

  function automatic logic [13:0] coef(input int s);
    return 14'((s * 1237 + 77) % 16384);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_block(input logic src);
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      e.src  = src;
      e.idx  = 4'(i);
      e.yn   = coef(exp_seq);
      e.last = (i == 15);
      sb_q.push_back(e);
      exp_seq++;
    end
  endtask

  // Monitor: every presented coefficient must match the queue head.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_out_valid", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          chk("out_beat{src,idx,yn,last}", {out_src, out_idx, out_yn, out_last}, 64'(e));
        end
      end
    end
  end

  // Transform core model: accepts rows, answers each 4-row block with 16 coefficients.
  initial begin : core_rx
    forever begin
      @(negedge clk);
      if (!rst_n) rows_rx = 0;
      else if (tx_enable) rows_rx++;
    end
  end

  initial begin : core_tx
    int beat;
    int seq;
    beat = 0;
    seq = 0;
    tx_valid = 1'b0;
    tx_yn = '0;
    forever begin
      @(posedge clk); #1;
      tx_valid = 1'b0;
      if (!rst_n) begin
        beat = 0;
        blks_out = 0;
      end else if (inj_done < inj_req) begin
        tx_valid = 1'b1;
        tx_yn = 14'h1ABC;
        inj_done++;
      end else if ((rows_rx / 4) > blks_out) begin
        tx_valid = 1'b1;
        tx_yn = coef(seq);
        seq++;
        beat++;
        if (beat == 16) begin
          beat = 0;
          blks_out++;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive_src(input logic src, input logic req, input logic [35:0] xx);
    if (src) begin chroma_req = req; chroma_xx = xx; end
    else     begin luma_req = req;   luma_xx = xx;   end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    luma_req = 1'b0; chroma_req = 1'b0;
    m1_luma_req = 1'b0; m1_tx_valid = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic drain(input string name);
    int c;
    c = 0;
    while (sb_q.size() != 0 && c < 400) begin step(); c++; end
    repeat (3) step();
    chk(name, 64'(sb_q.size()), 64'd0);
  endtask

  // Issues one single-source block, expecting row 0 in the very first cycle.
  task automatic issue_one(input logic src, input logic [35:0] base);
    expect_block(src);
    drive_src(src, 1'b1, base);
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      chk("row_enable", 64'(tx_enable), 64'd1);
      chk("row_data", 64'(tx_xxin), 64'(base + 36'(r)));
      chk("row_ack{l,c}", {luma_ack, chroma_ack}, src ? 64'd1 : 64'd2);
      step();
      if (r == 3) drive_src(src, 1'b0, 36'd0);
      else        drive_src(src, 1'b1, base + 36'(r + 1));
    end
  endtask

  initial begin : main
    logic [9:0] gseq;
    logic       g;
    int         c;
    rst_n = 1'b0;
    luma_req = 1'b0; chroma_req = 1'b0; luma_xx = '0; chroma_xx = '0; tx_ready = 1'b1;
    m1_luma_req = 1'b0; m1_chroma_req = 1'b0; m1_luma_xx = '0; m1_chroma_xx = '0;
    m1_tx_ready = 1'b1; m1_tx_valid = 1'b0; m1_tx_yn = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs{vld,yn,src,idx,last,err}",
        {out_valid, out_yn, out_src, out_idx, out_last, err}, 64'd0);
    chk("reset_tx_enable", 64'(tx_enable), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // Luma-only block, rows 1..4
    issue_one(1'b0, 36'h1);
    drain("A_drain");

    // TX_READY low holds off issue; rising edge issues row 0 immediately
    tx_ready = 1'b0;
    drive_src(1'b0, 1'b1, 36'h1_2345_6789);
    repeat (5) begin
      @(negedge clk);
      chk("B_held_enable", {tx_enable, luma_ack}, 64'd0);
      step();
    end
    tx_ready = 1'b1;
    issue_one(1'b0, 36'h1_2345_6789);
    drain("B_drain");

    // Both sources requesting: L,L,L,L,C,L,L,L,L,C
    do_reset();
    gseq = 10'b10_0001_0000;
    for (int k = 0; k < 10; k++) expect_block(gseq[k]);
    luma_req = 1'b1; chroma_req = 1'b1;
    luma_xx = 36'hA_AAAA_0001; chroma_xx = 36'hC_CCCC_0002;
    for (int k = 0; k < 10; k++) begin
      g = gseq[k];
      c = 0;
      while (1) begin
        @(negedge clk);
        if (tx_enable || c > 100) break;
        c++;
        step();
      end
      chk("C_row0_timeout", 64'(c > 100), 64'd0);
      for (int r = 0; r < 4; r++) begin
        if (r > 0) @(negedge clk);
        chk("C_enable", 64'(tx_enable), 64'd1);
        chk("C_grant{l,c}", {luma_ack, chroma_ack}, g ? 64'd1 : 64'd2);
        chk("C_data", 64'(tx_xxin), g ? 64'h0C_CCCC_0002 : 64'h0A_AAAA_0001);
        step();
        if (k == 9 && r == 3) begin luma_req = 1'b0; chroma_req = 1'b0; end
      end
    end
    drain("C_drain");

    // Luma REQ dropped after row 1: ERR, rows 2..3 still issued
    do_reset();
    expect_block(1'b0);
    drive_src(1'b0, 1'b1, 36'h10);
    @(negedge clk); chk("D_row0", {tx_enable, luma_ack}, 64'd3); step();
    luma_xx = 36'h11;
    @(negedge clk); chk("D_row1", {tx_enable, luma_ack}, 64'd3); step();
    luma_req = 1'b0;
    @(negedge clk); chk("D_row2_issued", {tx_enable, luma_ack}, 64'd3);
    chk("D_err_before", 64'(err), 64'd0); step();
    @(negedge clk); chk("D_row3_issued", {tx_enable, luma_ack}, 64'd3);
    chk("D_err_set", 64'(err), 64'd1); step();
    drain("D_drain");
    chk("D_err_sticky", 64'(err), 64'd1);

    // Reset during row 2 abandons the block; next block runs normally
    drive_src(1'b0, 1'b1, 36'h5);
    @(negedge clk); chk("E_row0", 64'(tx_enable), 64'd1); step();
    luma_xx = 36'h6;
    @(negedge clk); chk("E_row1", 64'(tx_enable), 64'd1); step();
    rst_n = 1'b0; luma_req = 1'b0;
    @(negedge clk);
    chk("E_reset_outputs{vld,yn,src,idx,last,err}",
        {out_valid, out_yn, out_src, out_idx, out_last, err}, 64'd0);
    chk("E_reset_tx", {tx_enable, luma_ack, chroma_ack}, 64'd0);
    step(); step();
    rst_n = 1'b1;
    step();
    issue_one(1'b0, 36'h77);
    drain("E_drain");

    // TX_VALID with nothing in flight: ERR and no OUT_VALID
    chk("D2_err_clear", 64'(err), 64'd0);
    @(negedge clk);
    inj_req++;
    @(negedge clk); chk("D2_no_out_a", 64'(out_valid), 64'd0);
    @(negedge clk); chk("D2_no_out_b", 64'(out_valid), 64'd0);
    chk("D2_err_empty_fifo", 64'(err), 64'd1);
    step();

    // MAX_INFLIGHT=1: second block waits for the index-15 pop cycle
    do_reset();
    m1_luma_req = 1'b1; m1_luma_xx = 36'hF0F;
    for (int r = 0; r < 4; r++) begin
      @(negedge clk); chk("F_blk1_row", 64'(m1_tx_enable), 64'd1); step();
    end
    repeat (3) begin
      @(negedge clk); chk("F_blocked", 64'(m1_tx_enable), 64'd0); step();
    end
    for (int i = 0; i < 16; i++) begin
      m1_tx_valid = 1'b1;
      m1_tx_yn = 14'(100 + i);
      @(negedge clk);
      if (i == 15) chk("F_issue_at_pop", 64'(m1_tx_enable), 64'd1);
      else         chk("F_wait_pop", 64'(m1_tx_enable), 64'd0);
      step();
    end
    m1_tx_valid = 1'b0;
    @(negedge clk);
    chk("F_last_beat{last,src,idx,yn}", {m1_out_last, m1_out_src, m1_out_idx, m1_out_yn},
        {1'b1, 1'b0, 4'd15, 14'd115});
    chk("F_blk2_row1", 64'(m1_tx_enable), 64'd1);
    step();
    repeat (2) begin
      @(negedge clk); chk("F_blk2_row", 64'(m1_tx_enable), 64'd1); step();
    end
    m1_luma_req = 1'b0;
    @(negedge clk); chk("F_no_err", 64'(m1_err), 64'd0);
    step();

    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
